// File: rtl/axi_pkg.sv
// Shared AXI types, constants and helpers for the dual-port memory slave.
// Bus widths come from `AXI_ADDR_WIDTH / `AXI_DATA_WIDTH (both default to 32).
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

package axi_pkg;

    localparam int AXI_ADDR_W   = `AXI_ADDR_WIDTH;
    localparam int AXI_DATA_W   = `AXI_DATA_WIDTH;
    localparam int STRB_WIDTH   = AXI_DATA_W / 8;
    localparam int AXI_4K_BYTES = 4096;

    typedef logic [AXI_ADDR_W-1:0] addr_t;
    typedef logic [7:0]            len_t;
    typedef logic [2:0]            size_t;
    typedef logic [STRB_WIDTH-1:0] strb_t;

    typedef enum logic [2:0] {
        ONE_BYTE        = 3'd0,
        TWO_BYTES       = 3'd1,
        FOUR_BYTES      = 3'd2,
        EIGHT_BYTES     = 3'd3,
        SIXTEEN_BYTES   = 3'd4,
        THIRTYTWO_BYTES = 3'd5,
        SIXTYFOUR_BYTES = 3'd6,
        ONE28_BYTES     = 3'd7
    } size_enum_t;

    typedef enum logic [1:0] {
        FIXED    = 2'b00,
        INCR     = 2'b01,
        WRAP     = 2'b10,
        RESERVED = 2'b11
    } burst_enum_t;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_enum_t;

    function automatic logic [7:0] size_to_bytes(input size_enum_t size);
        return 8'd1 << size;
    endfunction

endpackage

// File: rtl/axi_strb_gen.sv
// Combinational byte-lane strobe for one beat: lanes from the address offset up
// to the end of the size-aligned container are active. Shared with the write path.
module axi_strb_gen
    import axi_pkg::*;
#(
    parameter  int ADDR_WIDTH = AXI_ADDR_W,
    parameter  int DATA_WIDTH = AXI_DATA_W,
    localparam int STRB_W     = DATA_WIDTH / 8
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  size_t                 size,
    output logic [STRB_W-1:0]     strb
);

    localparam int OFF_W = (STRB_W > 1) ? $clog2(STRB_W) : 1;

    int unsigned bytes;
    int unsigned lane_lo;
    int unsigned lane_hi;

    // NOTE: every output is assigned before any condition, so no path can infer a latch.
    always_comb begin
        bytes   = 32'(size_to_bytes(size_enum_t'(size)));
        lane_lo = 32'(addr[OFF_W-1:0]) % STRB_W;
        lane_hi = ((32'(addr[OFF_W-1:0]) & ~(bytes - 1)) % STRB_W) + bytes - 1;
        strb    = '0;
        for (int unsigned i = 0; i < STRB_W; i++) begin
            strb[i] = (i >= lane_lo) && (i <= lane_hi);
        end
    end

endmodule

// File: rtl/axi_burst_addr_gen.sv
// Per-beat AXI address/strobe generator for FIXED, INCR and WRAP bursts.
// Optional: define AXI_4K_CHECK_EN to flag INCR bursts that cross a 4 KB page.
module axi_burst_addr_gen
    import axi_pkg::*;
#(
    parameter  int ADDR_WIDTH = AXI_ADDR_W,
    parameter  int DATA_WIDTH = AXI_DATA_W,
    localparam int STRB_W     = DATA_WIDTH / 8
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  len_t                  req_len,
    input  size_t                 req_size,
    input  logic [1:0]            req_burst,
    output logic                  beat_valid,
    input  logic                  beat_ready,
    output logic [ADDR_WIDTH-1:0] beat_addr,
    output logic [STRB_W-1:0]     beat_strb,
    output len_t                  beat_idx,
    output logic                  beat_last,
    output logic                  beat_err,
    output logic                  busy
);

    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

    // S_INIT holds req_ready low for the first cycle after reset release.
    typedef enum logic [1:0] {S_INIT, S_IDLE, S_BURST} state_t;

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   cur_addr, wrap_lo, wrap_end;
    len_t                    len_q, idx_q;
    size_enum_t              size_q;
    burst_enum_t             burst_q;
    logic                    err_q;

    logic                    accept, advance, last;
    logic                    req_err;
    logic [ADDR_WIDTH-1:0]   req_bytes, req_aligned, req_wrap_bytes, req_wrap_lo;
    logic [ADDR_WIDTH-1:0]   cur_bytes, step_addr, next_addr;
    logic [STRB_W-1:0]       lane_strb;

    assign accept  = req_valid && req_ready;
    assign advance = beat_valid && beat_ready;
    assign last    = (idx_q == len_q);

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        beat_valid = 1'b0;
        busy       = 1'b0;
        case (state)
            S_INIT: state_next = S_IDLE;
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = S_BURST;
            end
            S_BURST: begin
                busy       = 1'b1;
                beat_valid = 1'b1;
                if (beat_ready && last) state_next = S_IDLE;
            end
            default: state_next = S_INIT;
        endcase
    end

    // Command legality is judged once, at accept, and then carried for the whole burst.
`ifdef AXI_4K_CHECK_EN
    localparam int PAGE_LSB = $clog2(AXI_4K_BYTES);
    logic [ADDR_WIDTH-1:0] req_last_addr;
`endif

    always_comb begin
        req_bytes      = ADDR_WIDTH'(size_to_bytes(size_enum_t'(req_size)));
        req_aligned    = req_addr & ~(req_bytes - ONE);
        req_wrap_bytes = (ADDR_WIDTH'(req_len) + ONE) * req_bytes;
        req_wrap_lo    = req_addr & ~(req_wrap_bytes - ONE);
        req_err        = 1'b0;
        if (req_burst == RESERVED) req_err = 1'b1;
        if (req_bytes > ADDR_WIDTH'(STRB_W)) req_err = 1'b1;
        if (req_burst == WRAP && !(req_len inside {8'd1, 8'd3, 8'd7, 8'd15})) req_err = 1'b1;
        if (req_burst == WRAP && (req_addr & (req_bytes - ONE)) != '0) req_err = 1'b1;
`ifdef AXI_4K_CHECK_EN
        req_last_addr = req_aligned + ADDR_WIDTH'(req_len) * req_bytes;
        if (req_burst == INCR &&
            req_last_addr[ADDR_WIDTH-1:PAGE_LSB] != req_addr[ADDR_WIDTH-1:PAGE_LSB])
            req_err = 1'b1;
`endif
    end

    // Erroneous bursts keep the FIXED address so the beat count stays consistent.
    always_comb begin
        cur_bytes = ADDR_WIDTH'(size_to_bytes(size_q));
        step_addr = (cur_addr & ~(cur_bytes - ONE)) + cur_bytes;
        next_addr = cur_addr;
        if (!err_q) begin
            case (burst_q)
                INCR:    next_addr = step_addr;
                WRAP:    next_addr = (step_addr == wrap_end) ? wrap_lo : step_addr;
                default: next_addr = cur_addr;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state    <= S_INIT;
            cur_addr <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            size_q   <= ONE_BYTE;
            burst_q  <= FIXED;
            err_q    <= 1'b0;
            wrap_lo  <= '0;
            wrap_end <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                cur_addr <= req_addr;
                len_q    <= req_len;
                idx_q    <= '0;
                size_q   <= size_enum_t'(req_size);
                burst_q  <= burst_enum_t'(req_burst);
                err_q    <= req_err;
                wrap_lo  <= req_wrap_lo;
                wrap_end <= req_wrap_lo + req_wrap_bytes;
            end else if (advance && !last) begin
                cur_addr <= next_addr;
                idx_q    <= idx_q + 8'd1;
            end
        end
    end

    axi_strb_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_strb_gen (
        .addr (cur_addr),
        .size (size_q),
        .strb (lane_strb)
    );

    assign beat_addr = cur_addr;
    assign beat_idx  = idx_q;
    assign beat_last = beat_valid && last;
    assign beat_err  = beat_valid && err_q;
    assign beat_strb = (beat_valid && !err_q) ? lane_strb : '0;

endmodule

// File: tb/tb_axi_burst_addr_gen.sv
// Self-checking bench for axi_burst_addr_gen: directed table, stall/reset
// sequence, 256-beat burst and randomized commands against a closed-form model.
`timescale 1ns/1ps
module tb_axi_burst_addr_gen;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          ACLK = 1'b0;
    logic          ARESETn = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_addr = '0;
    logic [7:0]    req_len = '0;
    logic [2:0]    req_size = '0;
    logic [1:0]    req_burst = '0;
    logic          beat_valid;
    logic          beat_ready = 1'b0;
    logic [AW-1:0] beat_addr;
    logic [SW-1:0] beat_strb;
    logic [7:0]    beat_idx;
    logic          beat_last;
    logic          beat_err;
    logic          busy;

    axi_burst_addr_gen #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .ACLK       (ACLK),
        .ARESETn    (ARESETn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .req_size   (req_size),
        .req_burst  (req_burst),
        .beat_valid (beat_valid),
        .beat_ready (beat_ready),
        .beat_addr  (beat_addr),
        .beat_strb  (beat_strb),
        .beat_idx   (beat_idx),
        .beat_last  (beat_last),
        .beat_err   (beat_err),
        .busy       (busy)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_pass   = 0;

    logic [AW-1:0] got_addr [256];
    logic [SW-1:0] got_strb [256];
    logic [7:0]    got_idx  [256];
    logic          got_last [256];
    logic          got_err  [256];
    int            got_n;

    int wrap_lens [4] = '{1, 3, 7, 15};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model (closed form per beat) ----------------
    function automatic bit m_err(input logic [31:0] a, input int len, input int size, input int burst);
        int unsigned bytes;
        bit          err;
`ifdef AXI_4K_CHECK_EN
        logic [31:0] last_a;
`endif
        bytes = 32'd1 << size;
        err   = (burst == 3) || (bytes > SW);
        if (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) err = 1'b1;
        if (burst == 2 && (a % bytes) != 0) err = 1'b1;
`ifdef AXI_4K_CHECK_EN
        if (burst == 1) begin
            last_a = (a / bytes) * bytes + len * bytes;
            if ((last_a / 4096) != (a / 4096)) err = 1'b1;
        end
`endif
        return err;
    endfunction

    function automatic logic [31:0] m_addr(input logic [31:0] a, input int len, input int size,
                                           input int burst, input bit err, input int n);
        int unsigned bytes;
        int unsigned wb;
        logic [31:0] lower;
        bytes = 32'd1 << size;
        if (err || burst == 0) return a;
        if (burst == 1) return (n == 0) ? a : (a / bytes) * bytes + n * bytes;
        wb    = (len + 1) * bytes;
        lower = (a / wb) * wb;
        return lower + ((a - lower + n * bytes) % wb);
    endfunction

    function automatic logic [SW-1:0] m_strb(input logic [31:0] a, input int size, input bit err);
        int unsigned   bytes, lo, hi;
        logic [SW-1:0] s;
        s = '0;
        if (err) return s;
        bytes = 32'd1 << size;
        lo    = a % SW;
        hi    = ((a / bytes) * bytes) % SW + bytes - 1;
        for (int unsigned i = 0; i < SW; i++) s[i] = (i >= lo) && (i <= hi);
        return s;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic send_cmd(input logic [31:0] a, input int len, input int size, input int burst);
        int w;
        w = 0;
        while (req_ready !== 1'b1 && w < 50) begin
            @(negedge ACLK);
            w++;
        end
        check("accept_ready", req_ready, 1);
        req_valid = 1'b1;
        req_addr  = a;
        req_len   = 8'(len);
        req_size  = 3'(size);
        req_burst = 2'(burst);
        @(negedge ACLK);
        req_valid = 1'b0;
    endtask

    task automatic do_burst(input logic [31:0] a, input int len, input int size,
                            input int burst, input int stall_pct);
        int          cycles, proto, unstable;
        bit          stalled, r;
        logic [45:0] snap, cur;
        send_cmd(a, len, size, burst);
        check("first_beat_latency", beat_valid, 1);
        got_n = 0; cycles = 0; proto = 0; unstable = 0; stalled = 0; snap = '0;
        while (got_n <= len && cycles < 20 * (len + 1) + 50) begin
            cur = {beat_addr, beat_strb, beat_idx, beat_last, beat_err};
            if (beat_valid !== 1'b1 || busy !== 1'b1 || req_ready !== 1'b0) proto++;
            if (stalled && cur !== snap) unstable++;
            r = ($urandom_range(99) >= stall_pct);
            beat_ready = r;
            if (beat_valid === 1'b1 && r) begin
                got_addr[got_n] = beat_addr;
                got_strb[got_n] = beat_strb;
                got_idx[got_n]  = beat_idx;
                got_last[got_n] = beat_last;
                got_err[got_n]  = beat_err;
                got_n++;
            end
            stalled = (beat_valid === 1'b1) && !r;
            snap    = cur;
            @(negedge ACLK);
            cycles++;
        end
        beat_ready = 1'b0;
        check("burst_beats", got_n, len + 1);
        check("in_burst_protocol", proto, 0);
        check("stall_stable", unstable, 0);
        check("bubble_req_ready", req_ready, 1);
        check("bubble_beat_valid", beat_valid, 0);
    endtask

    task automatic cmp_model(input logic [31:0] a, input int len, input int size, input int burst);
        bit          e;
        logic [31:0] ea;
        logic [45:0] exp, act;
        e = m_err(a, len, size, burst);
        for (int i = 0; i <= len && i < got_n; i++) begin
            ea  = m_addr(a, len, size, burst, e, i);
            exp = {ea, m_strb(ea, size, e), 8'(i), (i == len), e};
            act = {got_addr[i], got_strb[i], got_idx[i], got_last[i], got_err[i]};
            check($sformatf("model a=%0h len=%0d sz=%0d b=%0d beat%0d", a, len, size, burst, i), act, exp);
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [31:0]      addr;
        int               len;
        int               size;
        int               burst;
        int               n;
        bit               err;
        logic [3:0][31:0] ea;
        logic [3:0][3:0]  es;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] addr, input int len, input int size, input int burst,
                                input int n, input bit err,
                                input logic [31:0] a0, input logic [31:0] a1,
                                input logic [31:0] a2, input logic [31:0] a3,
                                input logic [3:0] s0, input logic [3:0] s1,
                                input logic [3:0] s2, input logic [3:0] s3);
        vec_t v;
        v.addr = addr; v.len = len; v.size = size; v.burst = burst; v.n = n; v.err = err;
        v.ea[0] = a0; v.ea[1] = a1; v.ea[2] = a2; v.ea[3] = a3;
        v.es[0] = s0; v.es[1] = s1; v.es[2] = s2; v.es[3] = s3;
        return v;
    endfunction

    localparam int NV = 11;
    vec_t vecs [NV];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          len, size, burst;
        logic [45:0] snap;

        //                  addr        len sz b  n err  addr0        addr1        addr2        addr3        strb0 strb1 strb2 strb3
        vecs[0]  = mk(32'h1002, 3, 2, 1, 4, 0, 32'h1002, 32'h1004, 32'h1008, 32'h100C, 4'hC, 4'hF, 4'hF, 4'hF);
        vecs[1]  = mk(32'h34,   3, 2, 2, 4, 0, 32'h34,   32'h38,   32'h3C,   32'h30,   4'hF, 4'hF, 4'hF, 4'hF);
        vecs[2]  = mk(32'h35,   3, 2, 2, 4, 1, 32'h35,   32'h35,   32'h35,   32'h35,   4'h0, 4'h0, 4'h0, 4'h0);
        vecs[3]  = mk(32'h22,   2, 1, 0, 3, 0, 32'h22,   32'h22,   32'h22,   32'h0,    4'hC, 4'hC, 4'hC, 4'h0);
        vecs[4]  = mk(32'h40,   1, 2, 3, 2, 1, 32'h40,   32'h40,   32'h0,    32'h0,    4'h0, 4'h0, 4'h0, 4'h0);
        vecs[5]  = mk(32'h100,  1, 3, 1, 2, 1, 32'h100,  32'h100,  32'h0,    32'h0,    4'h0, 4'h0, 4'h0, 4'h0);
`ifdef AXI_4K_CHECK_EN
        vecs[6]  = mk(32'hFF8,  3, 2, 1, 4, 1, 32'hFF8,  32'hFF8,  32'hFF8,  32'hFF8,  4'h0, 4'h0, 4'h0, 4'h0);
`else
        vecs[6]  = mk(32'hFF8,  3, 2, 1, 4, 0, 32'hFF8,  32'hFFC,  32'h1000, 32'h1004, 4'hF, 4'hF, 4'hF, 4'hF);
`endif
        vecs[7]  = mk(32'h7,    0, 0, 1, 1, 0, 32'h7,    32'h0,    32'h0,    32'h0,    4'h8, 4'h0, 4'h0, 4'h0);
        vecs[8]  = mk(32'h40,   2, 2, 2, 3, 1, 32'h40,   32'h40,   32'h40,   32'h0,    4'h0, 4'h0, 4'h0, 4'h0);
        vecs[9]  = mk(32'h1E,   7, 1, 2, 8, 0, 32'h1E,   32'h10,   32'h12,   32'h14,   4'hC, 4'h3, 4'hC, 4'h3);
        vecs[10] = mk(32'h3,    2, 0, 1, 3, 0, 32'h3,    32'h4,    32'h5,    32'h0,    4'h8, 4'h1, 4'h2, 4'h0);

        // Reset state
        repeat (3) @(negedge ACLK);
        check("rst_req_ready", req_ready, 0);
        check("rst_beat_valid", beat_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_outputs", {beat_addr, beat_strb, beat_idx, beat_last, beat_err}, 0);
        ARESETn = 1'b1;
        check("ready_before_first_edge", req_ready, 0);
        @(negedge ACLK);
        check("ready_after_first_edge", req_ready, 1);

        // Directed table
        for (int v = 0; v < NV; v++) begin
            do_burst(vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst, 25);
            check($sformatf("tbl%0d_beats", v), got_n, vecs[v].n);
            for (int i = 0; i < 4 && i < vecs[v].n && i < got_n; i++) begin
                check($sformatf("tbl%0d_addr%0d", v, i), got_addr[i], vecs[v].ea[i]);
                check($sformatf("tbl%0d_strb%0d", v, i), got_strb[i], vecs[v].es[i]);
                check($sformatf("tbl%0d_err%0d", v, i), got_err[i], vecs[v].err);
                check($sformatf("tbl%0d_last%0d", v, i), got_last[i], (i == vecs[v].n - 1));
            end
            cmp_model(vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst);
        end

        // Stall for 5 cycles mid-burst, then asynchronous reset
        send_cmd(32'h22, 2, 1, 0);
        check("stall_first_valid", beat_valid, 1);
        beat_ready = 1'b1;
        @(negedge ACLK);
        beat_ready = 1'b0;
        check("stall_idx", beat_idx, 1);
        check("stall_addr", beat_addr, 32'h22);
        check("stall_strb", beat_strb, 4'hC);
        snap = {beat_addr, beat_strb, beat_idx, beat_last, beat_err};
        for (int c = 0; c < 5; c++) begin
            @(negedge ACLK);
            check($sformatf("stall_hold%0d", c),
                  {beat_valid, beat_addr, beat_strb, beat_idx, beat_last, beat_err}, {1'b1, snap});
        end
        #2 ARESETn = 1'b0;
        #1;
        check("async_rst_valid", beat_valid, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_idx", beat_idx, 0);
        check("async_rst_addr", beat_addr, 0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        check("rerst_ready_low", req_ready, 0);
        @(negedge ACLK);
        check("rerst_ready_high", req_ready, 1);

        // Maximum-length burst
        do_burst(32'h0, 255, 0, 1, 20);
        check("len255_last_addr", got_addr[255], 32'hFF);
        check("len255_last_idx", got_idx[255], 8'd255);
        check("len255_last_flag", got_last[255], 1);
        check("len254_not_last", got_last[254], 0);
        cmp_model(32'h0, 255, 0, 1);

        // Randomized commands against the model
        for (int k = 0; k < 30; k++) begin
            case ($urandom_range(3))
                0:       a = 32'h0000_0FC0 + $urandom_range(63);
                1:       a = $urandom_range(255);
                default: a = $urandom;
            endcase
            size  = $urandom_range(3);
            burst = ($urandom_range(9) == 0) ? 3 : $urandom_range(2);
            case ($urandom_range(2))
                0:       len = wrap_lens[$urandom_range(3)];
                1:       len = $urandom_range(3);
                default: len = $urandom_range(40);
            endcase
            if (burst == 2 && $urandom_range(1) == 1) a = a & ~((32'd1 << size) - 1);
            do_burst(a, len, size, burst, $urandom_range(60));
            cmp_model(a, len, size, burst);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axi_burst_addr_gen.md
Name: axi_burst_addr_gen

Overview:
- Per-beat address generator shared by the read and write channels of the AXI dual-port memory slave.
- Accepts one captured AW/AR command (addr, len, size, burst) and emits len+1 beats through a valid/ready stream. Each beat carries the address, the byte-lane strobe mask, a last flag and an error flag.
- Downstream, the memory-access stage consumes one beat per RAM access.
- Implements the FIXED, INCR and WRAP burst rules and flags illegal commands.

Parameters:
- ADDR_WIDTH, 32 (`AXI_ADDR_WIDTH): address width.
- DATA_WIDTH, 32 (`AXI_DATA_WIDTH): data bus width. STRB_WIDTH = DATA_WIDTH/8.

Ports:
- ACLK  in  1  clock.
- ARESETn  in  1  asynchronous active-low reset.
- req_valid  in  1  command valid.
- req_ready  out  1  command accepted when high with req_valid.
- req_addr  in  ADDR_WIDTH  AxADDR.
- req_len  in  8  AxLEN (beats-1).
- req_size  in  3  AxSIZE.
- req_burst  in  2  AxBURST.
- beat_valid  out  1  beat available.
- beat_ready  in  1  downstream consumes beat.
- beat_addr  out  ADDR_WIDTH  byte address of this beat.
- beat_strb  out  STRB_WIDTH  active byte lanes.
- beat_idx  out  8  beat number, 0..len.
- beat_last  out  1  final beat of burst.
- beat_err  out  1  burst is illegal (SLVERR downstream).
- busy  out  1  burst in progress.

Behaviour:
- Clock and reset: single clock ACLK. ARESETn is asynchronous and active-low; all flops clear immediately on assertion.
- Reset values: beat_valid=0, beat_addr=0, beat_strb=0, beat_idx=0, beat_last=0, beat_err=0, busy=0, req_ready=0.
- req_ready rises on the first ACLK edge after reset release.
- Reset mid-burst: the burst is abandoned; beat_valid drops with reset and no partial state survives.
- States:
  - IDLE: req_ready=1. On req_valid&&req_ready, latch the command and go to BURST.
  - BURST: req_ready=0, busy=1. The first beat is valid on the cycle after acceptance, so latency is 1 cycle.
- Beat advance: each beat_valid&&beat_ready advances beat_idx.
- Burst end: the handshake with beat_idx==len (beat_last=1) returns the FSM to IDLE. req_ready is 1 the next cycle, giving one mandatory bubble between bursts.
- Stability: while beat_valid&&!beat_ready, all beat_* outputs hold stable.
- Address arithmetic:
  - bytes = 1<<size.
  - aligned = addr & ~(bytes-1).
  - All sums are modulo 2^ADDR_WIDTH.
- FIXED: every beat uses req_addr unchanged.
- INCR: beat 0 is req_addr; beat n is aligned + n*bytes.
- WRAP:
  - wrap_bytes = (len+1)*bytes; lower = addr & ~(wrap_bytes-1).
  - next = cur + bytes. If next == lower + wrap_bytes, next = lower.
- Strobe for beat address a:
  - lanes from (a mod STRB_WIDTH) through ((a & ~(bytes-1)) mod STRB_WIDTH) + bytes - 1 are set; all others are 0.
  - An unaligned first beat therefore gets a partial mask.
- Error conditions, evaluated once at accept:
  - burst==RESERVED;
  - bytes > STRB_WIDTH;
  - WRAP with len not in {1,3,7,15};
  - WRAP with an unaligned addr.
- On error:
  - all len+1 beats are still emitted, so the downstream stage stays beat-count-consistent;
  - beat_err=1 and beat_strb=0 on every beat;
  - beat_addr follows the FIXED rule.
- len=0: a single beat with beat_last=1 on beat 0.
- len=255: 256 beats. beat_idx must not overflow before beat_last.

Optional Feature:
- Macro: AXI_4K_CHECK_EN.
- Defined: an INCR burst whose final beat address lies in a different 4 KB page than req_addr is flagged as an error at accept, with the same handling as the other error conditions. The check uses aligned + len*bytes.
- Undefined: no page check. Addresses increment across the 4 KB boundary with beat_err=0.

Decomposition:
- axi_pkg additions:
  - resp_enum_t (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11);
  - constant AXI_4K_BYTES=4096;
  - function size_to_bytes(size_enum_t);
  - STRB_WIDTH derived from the defines.
- The block reuses addr_t, len_t, size_t, burst_enum_t and strb_t from the package.
- One natural sub-module: axi_strb_gen, a combinational block mapping (addr, size) to strb_t. It is instantiated once here and reused by the write path.

Test Plan:
- INCR, addr=0x1002, len=3, size=FOUR_BYTES, DATA_WIDTH=32 -> addr 0x1002,0x1004,0x1008,0x100C; strb 4'b1100,4'b1111,4'b1111,4'b1111; beat_last on beat 3; req_ready high 1 cycle after the last handshake.
- WRAP, addr=0x34, len=3, size=FOUR_BYTES -> 0x34,0x38,0x3C,0x30; beat_last with 0x30; beat_err=0. Same command with addr=0x35 -> 4 beats, err=1, strb=0.
- FIXED, addr=0x22, len=2, size=TWO_BYTES -> three beats at 0x22, strb 4'b1100 each. Hold beat_ready=0 for 5 cycles mid-burst -> all outputs constant; then assert ARESETn=0 -> beat_valid=0 immediately.
- Error commands: burst=RESERVED, len=1 -> 2 beats, err=1, strb=0. size=EIGHT_BYTES on a 32-bit bus -> err=1.
- INCR, addr=0xFF8, len=3, size=FOUR_BYTES -> with AXI_4K_CHECK_EN: 4 beats, err=1. Without it: 0xFF8,0xFFC,0x1000,0x1004, err=0.
- INCR, len=255, size=ONE_BYTE, addr=0 -> 256 beats ending at addr 0xFF, beat_idx=255 with beat_last=1.
